sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 121 ++++++++++++
 tb/tb_sram_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// 32-bit initiator to 16-bit asynchronous SRAM bridge: each word is moved as two halfword phases
// (LOW, then HIGH), each lasting HALF_CYCLES clocks, followed by a one-cycle completion pulse.
module sram_controller #(
    parameter int unsigned HALF_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_read,
    input  logic        sram_write,
    input  logic [31:0] sram_address,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [3:0] LAST     = 4'(HALF_CYCLES - 1);
    localparam logic [3:0] PRE_LAST = 4'(HALF_CYCLES - 2);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_t;

    state_t      state;
    logic [3:0]  count;
    logic        op_write;
    logic [16:0] word;
    logic [15:0] wdata_hi;
    logic [15:0] rdata_lo;
    logic [15:0] dq_out;
    logic        dq_oe;

    // Only the word-select bits reach the SRAM.
    logic unused_addr;
    assign unused_addr = ^{sram_address[31:19], sram_address[1:0]};

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            count      <= '0;
            op_write   <= 1'b0;
            word       <= '0;
            wdata_hi   <= '0;
            rdata_lo   <= '0;
            dq_out     <= '0;
            dq_oe      <= 1'b0;
            sram_rdata <= '0;
            sram_ready <= 1'b0;
            SRAM_ADDR  <= '0;
            SRAM_WE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    // Write wins over a simultaneous read.
                    if (sram_write || sram_read) begin
                        state     <= StLow;
                        count     <= '0;
                        op_write  <= sram_write;
                        word      <= sram_address[18:2];
                        wdata_hi  <= sram_wdata[31:16];
                        dq_out    <= sram_wdata[15:0];
                        dq_oe     <= sram_write;
                        SRAM_ADDR <= {sram_address[18:2], 1'b0};
                        SRAM_OE_N <= sram_write;
                        SRAM_WE_N <= !sram_write;
                    end
                end
                StLow: begin
                    if (count == LAST) begin
                        state     <= StHigh;
                        count     <= '0;
                        SRAM_ADDR <= {word, 1'b1};
                        SRAM_WE_N <= !op_write;
                        dq_out    <= wdata_hi;
                        if (!op_write) begin
                            rdata_lo <= SRAM_DQ;
                        end
                    end else begin
                        count     <= count + 4'd1;
                        // Release the strobe one cycle early so address and data are held.
                        SRAM_WE_N <= !op_write || (count == PRE_LAST);
                    end
                end
                StHigh: begin
                    if (count == LAST) begin
                        state      <= StDone;
                        count      <= '0;
                        sram_ready <= 1'b1;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_OE_N  <= 1'b1;
                        dq_oe      <= 1'b0;
                        if (!op_write) begin
                            sram_rdata <= {SRAM_DQ, rdata_lo};
                        end
                    end else begin
                        count     <= count + 4'd1;
                        SRAM_WE_N <= !op_write || (count == PRE_LAST);
                    end
                end
                StDone: begin
                    state      <= StIdle;
                    sram_ready <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed transactions against a behavioural halfword SRAM, with a
// scoreboard queue holding the read data expected at each completion pulse.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sram_read = 1'b0;
    logic        sram_write = 1'b0;
    logic [31:0] sram_address = '0;
    logic [31:0] sram_wdata = '0;
    logic [31:0] sram_rdata;
    logic        sram_ready;
    logic [17:0] ext_addr;
    wire  [15:0] ext_dq;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    logic        read4 = 1'b0;
    logic        write4 = 1'b0;
    logic [31:0] rdata4;
    logic        ready4;
    logic [17:0] addr4;
    wire  [15:0] dq4;
    logic        we_n4, oe_n4, ce_n4, ub_n4, lb_n4;

    always #5 clk = ~clk;

    sram_controller #(.HALF_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .sram_read(sram_read), .sram_write(sram_write),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .SRAM_ADDR(ext_addr), .SRAM_DQ(ext_dq), .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    sram_controller #(.HALF_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .sram_read(read4), .sram_write(write4),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(rdata4),
        .sram_ready(ready4), .SRAM_ADDR(addr4), .SRAM_DQ(dq4), .SRAM_WE_N(we_n4),
        .SRAM_OE_N(oe_n4), .SRAM_CE_N(ce_n4), .SRAM_UB_N(ub_n4), .SRAM_LB_N(lb_n4)
    );

    // Behavioural SRAM; probe_en lets the bench drive a pattern to detect a non-released bus.
    logic [15:0] mem [0:262143];
    logic        probe_en = 1'b0;
    wire         model_drv = !oe_n && we_n && !ce_n;
    assign ext_dq = model_drv ? mem[ext_addr] : (probe_en ? 16'h5A5A : 16'hzzzz);

    always @(posedge clk) begin
        if (!we_n && !ce_n) mem[ext_addr] <= ext_dq;
    end

    int          n_assert = 0;
    int          n_fail = 0;
    int          lat, we_low, oe_low;
    logic [17:0] addr_lo, addr_hi;
    logic [31:0] last_rd = '0;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [logic [16:0]];
    int          lat4, pulses4, we4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic probe_bus(input string tag);
        probe_en = 1'b1;
        #1;
        check(tag, {16'h0, ext_dq}, 32'h5A5A);
        probe_en = 1'b0;
    endtask

    // j counts negedges from the cycle in which the request was driven (that cycle is j=0).
    task automatic wait_ready(input int hold, input bit keep);
        lat = -1; we_low = 0; oe_low = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (!we_n) we_low++;
            if (!oe_n) oe_low++;
            if (j == 1) addr_lo = ext_addr;
            if (j == 3) addr_hi = ext_addr;
            if (hold > 0 && j == hold) begin
                sram_read = 1'b0; sram_write = 1'b0;
                sram_address = $urandom; sram_wdata = $urandom;
            end
            if (sram_ready) begin
                lat = j;
                if (exp_q.size() == 0) check("unexpected_ready", {31'd0, sram_ready}, 32'd0);
                else check("rdata", sram_rdata, exp_q.pop_front());
                if (!keep) begin sram_read = 1'b0; sram_write = 1'b0; end
                break;
            end
        end
        if (lat < 0 && exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int hold, input bit keep);
        @(posedge clk);
        #1;
        sram_read = rd; sram_write = wr; sram_address = addr; sram_wdata = data;
        if (wr) ref_mem[addr[18:2]] = data;
        else last_rd = ref_mem[addr[18:2]];
        exp_q.push_back(last_rd);
        wait_ready(hold, keep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check("rst_ready", {31'd0, sram_ready}, 32'd0);
        check("rst_rdata", sram_rdata, 32'd0);
        check("rst_addr", {14'd0, ext_addr}, 32'd0);
        check("rst_we_oe", {30'd0, we_n, oe_n}, 32'd3);
        probe_bus("rst_dq_hiz");
        @(negedge clk);
        rst = 1'b0;
        check("tied_low", {29'd0, ce_n, ub_n, lb_n}, 32'd0);

        // Write then read
        do_req(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1'b0);
        check("wr_latency", lat, 5);
        check("wr_we_low", we_low, 2);
        check("wr_oe_low", oe_low, 0);
        check("wr_addr_lo", {14'd0, addr_lo}, 32'h82);
        check("wr_addr_hi", {14'd0, addr_hi}, 32'h83);
        probe_bus("done_dq_hiz");
        check("mem_82", {16'h0, mem[18'h82]}, 32'hBEEF);
        check("mem_83", {16'h0, mem[18'h83]}, 32'hDEAD);
        do_req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 0, 1'b0);
        check("rd_latency", lat, 5);
        check("rd_oe_low", oe_low, 4);
        check("rd_we_low", we_low, 0);

        // Simultaneous read and write: write wins, rdata untouched
        do_req(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 0, 1'b0);
        check("simul_oe_low", oe_low, 0);
        check("mem_08", {16'h0, mem[18'h8]}, 32'h5678);
        check("mem_09", {16'h0, mem[18'h9]}, 32'h1234);

        // Read held across two addresses, switched in the ready cycle
        do_req(1'b0, 1'b1, 32'h0000_0020, 32'hA1A1_0020, 0, 1'b0);
        do_req(1'b0, 1'b1, 32'h0000_0024, 32'hB2B2_0024, 0, 1'b0);
        do_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b1);
        check("b2b_first", lat, 5);
        sram_address = 32'h0000_0024;
        do_req(1'b1, 1'b0, 32'h0000_0024, 32'h0, 0, 1'b0);
        check("b2b_second", lat, 5);

        // Request dropped after being sampled; inputs scrambled afterwards
        do_req(1'b0, 1'b1, 32'h0000_0040, 32'h0BAD_CAFE, 1, 1'b0);
        check("drop_latency", lat, 5);
        check("drop_we_low", we_low, 2);
        do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 1'b0);
        check("drop_readback_lat", lat, 5);

        // Top of the address space, upper address bits ignored
        do_req(1'b0, 1'b1, 32'hFFF7_FFFC, 32'hCAFE_F00D, 0, 1'b0);
        check("mem_3fffe", {16'h0, mem[18'h3FFFE]}, 32'hF00D);
        check("mem_3ffff", {16'h0, mem[18'h3FFFF]}, 32'hCAFE);
        do_req(1'b1, 1'b0, 32'h0007_FFFC, 32'h0, 0, 1'b0);
        check("wrap_addr_lo", {14'd0, addr_lo}, 32'h3FFFE);
        check("wrap_addr_hi", {14'd0, addr_hi}, 32'h3FFFF);

        // HALF_CYCLES=4 instance, request dropped after one cycle
        @(posedge clk);
        #1;
        sram_address = 32'h0000_0080; sram_wdata = 32'h4444_3333; write4 = 1'b1;
        lat4 = -1; pulses4 = 0; we4 = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (j == 1) write4 = 1'b0;
            if (!we_n4) we4++;
            if (ready4) begin
                pulses4++;
                if (lat4 < 0) lat4 = j;
            end
        end
        check("h4_latency", lat4, 9);
        check("h4_pulses", pulses4, 1);
        check("h4_we_low", we4, 6);

        // Reset in the HIGH phase of a write
        do_req(1'b0, 1'b1, 32'h0000_3000, 32'h1111_2222, 0, 1'b0);
        @(posedge clk);
        #1;
        sram_write = 1'b1; sram_address = 32'h0000_3000; sram_wdata = 32'hAAAA_BBBB;
        ref_mem[17'hC00] = 32'h1111_BBBB;
        repeat (3) @(posedge clk);
        #2;
        check("high_addr", {14'd0, ext_addr}, 32'h1801);
        check("high_we_low", {31'd0, we_n}, 32'd0);
        rst = 1'b1;
        // Readback request is already pending when reset is released.
        sram_write = 1'b0; sram_read = 1'b1;
        #1;
        check("async_rst_we_oe", {30'd0, we_n, oe_n}, 32'd3);
        check("async_rst_ready", {31'd0, sram_ready}, 32'd0);
        check("async_rst_rdata", sram_rdata, 32'd0);
        check("async_rst_addr", {14'd0, ext_addr}, 32'd0);
        probe_bus("async_rst_dq_hiz");
        last_rd = 32'h1111_BBBB;
        exp_q.push_back(last_rd);
        repeat (2) begin
            @(negedge clk);
            check("in_rst_ready", {31'd0, sram_ready}, 32'd0);
        end
        rst = 1'b0;
        // First edge after release samples the request, so DONE is 2*HALF_CYCLES negedges away.
        wait_ready(0, 1'b0);
        check("first_req_after_rst", lat, 4);
        check("mem_1800", {16'h0, mem[18'h1800]}, 32'hBBBB);
        check("mem_1801", {16'h0, mem[18'h1801]}, 32'h1111);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
